// File: rtl/iq_deserializer_pkg.sv
// Shared definitions for the I/Q deserializer: word sizes, sync pairs, tracker states.
package iq_deserializer_pkg;

  localparam int unsigned I_LEN_DEF = 14;
  localparam int unsigned Q_LEN_DEF = 14;

  typedef struct packed {
    logic rise;
    logic fall;
  } iq_pair_t;

  localparam iq_pair_t ISYNC = '{rise: 1'b1, fall: 1'b0};
  localparam iq_pair_t QSYNC = '{rise: 1'b0, fall: 1'b1};

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_t;

  // Clocks per frame: one pair per clock plus the two sync slots.
  function automatic int unsigned frame_len(input int unsigned i_len, input int unsigned q_len);
    return (i_len + q_len) / 2 + 2;
  endfunction

endpackage

// File: rtl/iq_deserializer_if.sv
// DDR pair input and reassembled sample output of the I/Q deserializer.
interface iq_deserializer_if #(
  parameter int unsigned I_LEN = 14,
  parameter int unsigned Q_LEN = 14
);
  logic             din_rise;
  logic             din_fall;
  logic [I_LEN-1:0] i_out;
  logic [Q_LEN-1:0] q_out;
  logic             sample_valid;
  logic             locked;
  logic [15:0]      sync_err_cnt;

  modport master (
    output din_rise, din_fall,
    input  i_out, q_out, sample_valid, locked, sync_err_cnt
  );

  modport slave (
    input  din_rise, din_fall,
    output i_out, q_out, sample_valid, locked, sync_err_cnt
  );
endinterface

// File: rtl/iq_sync_tracker.sv
// Frame sync tracker: slot counter, HUNT/VERIFY/LOCKED FSM, lock and miss counters.
module iq_sync_tracker
  import iq_deserializer_pkg::*;
#(
  parameter int unsigned I_LEN    = I_LEN_DEF,
  parameter int unsigned Q_LEN    = Q_LEN_DEF,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MISS_MAX = 2,
  localparam int unsigned SLOT_W  = $clog2(frame_len(I_LEN, Q_LEN))
) (
  input  logic              clk,
  input  logic              rst_n,
  input  iq_pair_t          i_pair,
  output logic [SLOT_W-1:0] o_slot,
  output logic              o_locked,
  output logic [15:0]       o_sync_err_cnt,
  output logic              o_frame_ok_c
);
  localparam int unsigned F      = frame_len(I_LEN, Q_LEN);
  localparam int unsigned QS     = I_LEN / 2 + 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(MISS_MAX + 1);
  localparam int unsigned ERR_W  = 16;

  sync_state_t       r_state, w_state_nxt;
  logic [SLOT_W-1:0] r_slot, w_slot_nxt;
  logic [GOOD_W-1:0] r_good, w_good_nxt, w_good_inc;
  logic [MISS_W-1:0] r_miss, w_miss_nxt, w_miss_inc;
  logic [ERR_W-1:0]  r_err, w_err_nxt;
  logic              r_isync_ok, w_isync_ok_nxt;
  logic              r_qsync_ok, w_qsync_ok_nxt;
  logic              r_locked;
  logic              w_chk_i, w_chk_q, w_match;

  assign w_chk_i    = (r_slot == '0);
  assign w_chk_q    = (r_slot == SLOT_W'(QS));
  assign w_match    = w_chk_i ? (i_pair == ISYNC) : (i_pair == QSYNC);
  assign w_good_inc = r_good + GOOD_W'(1);
  assign w_miss_inc = r_miss + MISS_W'(1);

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_HUNT;
      r_slot     <= '0;
      r_good     <= '0;
      r_miss     <= '0;
      r_err      <= '0;
      r_isync_ok <= 1'b0;
      r_qsync_ok <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_slot     <= w_slot_nxt;
      r_good     <= w_good_nxt;
      r_miss     <= w_miss_nxt;
      r_err      <= w_err_nxt;
      r_isync_ok <= w_isync_ok_nxt;
      r_qsync_ok <= w_qsync_ok_nxt;
      r_locked   <= (w_state_nxt == ST_LOCKED);
    end
  end

  // Next state; the slot counter is parked at 0 while hunting.
  always_comb begin
    w_state_nxt    = r_state;
    w_slot_nxt     = (r_slot == SLOT_W'(F - 1)) ? '0 : r_slot + SLOT_W'(1);
    w_good_nxt     = r_good;
    w_miss_nxt     = r_miss;
    w_err_nxt      = r_err;
    w_isync_ok_nxt = r_isync_ok;
    w_qsync_ok_nxt = r_qsync_ok;
    unique case (r_state)
      ST_HUNT: begin
        w_slot_nxt = '0;
        if (i_pair == ISYNC) begin
          w_state_nxt    = ST_VERIFY;
          w_slot_nxt     = SLOT_W'(1);
          w_good_nxt     = GOOD_W'(1);
          w_isync_ok_nxt = 1'b1;
          w_qsync_ok_nxt = 1'b0;
        end
      end
      ST_VERIFY: begin
        if (w_chk_i || w_chk_q) begin
          if (w_chk_i) w_isync_ok_nxt = w_match;
          else         w_qsync_ok_nxt = w_match;
          if (w_match) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == GOOD_W'(LOCK_CNT)) begin
              w_state_nxt = ST_LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_state_nxt = ST_HUNT;
            w_slot_nxt  = '0;
            w_good_nxt  = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (w_chk_i || w_chk_q) begin
          if (w_chk_i) w_isync_ok_nxt = w_match;
          else         w_qsync_ok_nxt = w_match;
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            w_miss_nxt = w_miss_inc;
            if (r_err != '1) w_err_nxt = r_err + ERR_W'(1);
            if (w_miss_inc == MISS_W'(MISS_MAX)) begin
              w_state_nxt = ST_HUNT;
              w_slot_nxt  = '0;
              w_good_nxt  = '0;
            end
          end
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
        w_slot_nxt  = '0;
      end
    endcase
  end

  // Outputs; a frame is released on its last slot only if both syncs matched.
  always_comb begin
    o_frame_ok_c = (r_state == ST_LOCKED) && (r_slot == SLOT_W'(F - 1))
                   && r_isync_ok && r_qsync_ok;
  end

  assign o_slot         = r_slot;
  assign o_locked       = r_locked;
  assign o_sync_err_cnt = r_err;

endmodule

// File: rtl/iq_deserializer.sv
// DDR I/Q deserializer: input inversion, I/Q shift registers and sample output registers.
module iq_deserializer
  import iq_deserializer_pkg::*;
#(
  parameter int unsigned I_LEN    = I_LEN_DEF,
  parameter int unsigned Q_LEN    = Q_LEN_DEF,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MISS_MAX = 2,
  parameter bit          INVERT   = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  iq_deserializer_if.slave  bus
);
  localparam int unsigned F      = frame_len(I_LEN, Q_LEN);
  localparam int unsigned SLOT_W = $clog2(F);
  localparam int unsigned QS     = I_LEN / 2 + 1;

  iq_pair_t          w_pair;
  logic [SLOT_W-1:0] w_slot;
  logic              w_locked;
  logic              w_frame_ok;
  logic [15:0]       w_err;
  logic              w_i_shift, w_q_shift;
  logic [I_LEN-1:0]  r_i_sr, r_i_out;
  logic [Q_LEN-1:0]  r_q_sr, r_q_out, w_q_word;
  logic              r_valid;

  assign w_pair    = {bus.din_rise ^ INVERT, bus.din_fall ^ INVERT};
  assign w_i_shift = (w_slot != '0) && (w_slot <= SLOT_W'(I_LEN / 2));
  assign w_q_shift = (w_slot > SLOT_W'(QS));
  // The last Q pair is merged straight into the output word for 1-clk latency.
  assign w_q_word  = {r_q_sr[Q_LEN-3:0], w_pair};

  iq_sync_tracker #(
    .I_LEN    (I_LEN),
    .Q_LEN    (Q_LEN),
    .LOCK_CNT (LOCK_CNT),
    .MISS_MAX (MISS_MAX)
  ) u_tracker (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pair         (w_pair),
    .o_slot         (w_slot),
    .o_locked       (w_locked),
    .o_sync_err_cnt (w_err),
    .o_frame_ok_c   (w_frame_ok)
  );

  // Shift registers and output sample registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i_sr  <= '0;
      r_q_sr  <= '0;
      r_i_out <= '0;
      r_q_out <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_i_shift) r_i_sr <= {r_i_sr[I_LEN-3:0], w_pair};
      if (w_q_shift) r_q_sr <= w_q_word;
      r_valid <= w_frame_ok;
      if (w_frame_ok) begin
        r_i_out <= r_i_sr;
        r_q_out <= w_q_word;
      end
    end
  end

  assign bus.i_out        = r_i_out;
  assign bus.q_out        = r_q_out;
  assign bus.sample_valid = r_valid;
  assign bus.locked       = w_locked;
  assign bus.sync_err_cnt = w_err;

endmodule

// File: tb/tb_iq_deserializer.sv
// Bench: a normal and an INVERT=1 deserializer fed the same logical stream, scoreboarded.
`timescale 1ns/1ps
module tb_iq_deserializer;
  import iq_deserializer_pkg::*;

  localparam int unsigned I_LEN = 14;
  localparam int unsigned Q_LEN = 14;
  localparam int unsigned F     = frame_len(I_LEN, Q_LEN);
  localparam int unsigned QS    = I_LEN / 2 + 1;

  typedef struct {
    logic [13:0] i;
    logic [13:0] q;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q_n[$];
  exp_t q_i[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iq_deserializer_if #(.I_LEN(I_LEN), .Q_LEN(Q_LEN)) bus_n ();
  iq_deserializer_if #(.I_LEN(I_LEN), .Q_LEN(Q_LEN)) bus_i ();

  iq_deserializer #(.I_LEN(I_LEN), .Q_LEN(Q_LEN), .LOCK_CNT(4), .MISS_MAX(2), .INVERT(1'b0))
    dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));
  iq_deserializer #(.I_LEN(I_LEN), .Q_LEN(Q_LEN), .LOCK_CNT(4), .MISS_MAX(2), .INVERT(1'b1))
    dut_i (.clk(clk), .rst_n(rst_n), .bus(bus_i));

  // Scoreboard monitors, one per DUT.
  always @(negedge clk) begin
    exp_t e;
    if (bus_n.sample_valid === 1'b1) begin
      checks++;
      if (q_n.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid_norm cyc=%0d i=%h q=%h", cyc, bus_n.i_out, bus_n.q_out);
      end else begin
        e = q_n.pop_front();
        if (bus_n.i_out !== e.i || bus_n.q_out !== e.q || cyc != e.cyc) begin
          errors++;
          $display("FAIL sample_norm got i=%h q=%h cyc=%0d want i=%h q=%h cyc=%0d",
                   bus_n.i_out, bus_n.q_out, cyc, e.i, e.q, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_i.sample_valid === 1'b1) begin
      checks++;
      if (q_i.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid_inv cyc=%0d i=%h q=%h", cyc, bus_i.i_out, bus_i.q_out);
      end else begin
        e = q_i.pop_front();
        if (bus_i.i_out !== e.i || bus_i.q_out !== e.q || cyc != e.cyc) begin
          errors++;
          $display("FAIL sample_inv got i=%h q=%h cyc=%0d want i=%h q=%h cyc=%0d",
                   bus_i.i_out, bus_i.q_out, cyc, e.i, e.q, e.cyc);
        end
      end
    end
  end

  function automatic logic [31:0] make_frame(input logic [13:0] i, input logic [13:0] q);
    return {2'b10, i, 2'b01, q};
  endfunction

  // Present one pair; returns #1 after the edge that sampled it.
  task automatic send_pair(input logic r, input logic f);
    bus_n.din_rise = r;
    bus_n.din_fall = f;
    bus_i.din_rise = ~r;
    bus_i.din_fall = ~f;
    @(posedge clk);
    #1;
  endtask

  task automatic send_range(input logic [31:0] fr, input int s0, input int s1);
    logic [1:0] p;
    for (int s = s0; s <= s1; s++) begin
      p = fr[31-2*s -: 2];
      send_pair(p[1], p[0]);
    end
  endtask

  task automatic push_exp(input logic [13:0] i, input logic [13:0] q);
    exp_t e;
    e.i = i;
    e.q = q;
    e.cyc = cyc;
    q_n.push_back(e);
    q_i.push_back(e);
  endtask

  task automatic send_frame(input logic [13:0] i, input logic [13:0] q, input logic exp_valid);
    send_range(make_frame(i, q), 0, F - 1);
    if (exp_valid) push_exp(i, q);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    send_pair(1'b0, 1'b0);
    rst_n = 1'b1;
    q_n.delete();
    q_i.delete();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send_pair(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    send_pair(1'b0, 1'b0);
    send_pair(1'b1, 1'b0);
    checks++;
    if (bus_n.i_out !== 14'h0 || bus_n.q_out !== 14'h0 || bus_i.i_out !== 14'h0 || bus_i.q_out !== 14'h0) begin
      errors++;
      $display("FAIL reset_words got n=%h/%h inv=%h/%h want 0", bus_n.i_out, bus_n.q_out, bus_i.i_out, bus_i.q_out);
    end
    checks++;
    if (bus_n.sample_valid !== 1'b0 || bus_i.sample_valid !== 1'b0 || bus_n.locked !== 1'b0 || bus_i.locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got valid=%b/%b locked=%b/%b want 0", bus_n.sample_valid, bus_i.sample_valid, bus_n.locked, bus_i.locked);
    end
    checks++;
    if (bus_n.sync_err_cnt !== 16'h0 || bus_i.sync_err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_errcnt got %h/%h want 0", bus_n.sync_err_cnt, bus_i.sync_err_cnt);
    end
    rst_n = 1'b1;
    // Stuck-at lines never present an ISYNC pair.
    for (int k = 0; k < 2 * F; k++) send_pair(1'b0, 1'b0);
    for (int k = 0; k < 2 * F; k++) send_pair(1'b1, 1'b1);
    checks++;
    if (bus_n.locked !== 1'b0 || bus_i.locked !== 1'b0 || bus_n.sync_err_cnt !== 16'h0 || bus_i.sync_err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL stuck_line got locked=%b/%b err=%h/%h want 0", bus_n.locked, bus_i.locked, bus_n.sync_err_cnt, bus_i.sync_err_cnt);
    end
  endtask

  task automatic test_clean();
    logic [31:0] fr;
    do_reset();
    fr = make_frame(14'h3003, 14'h0FFC);
    send_range(fr, 0, F - 1);
    send_range(fr, 0, QS - 1);
    checks++;
    if (bus_n.locked !== 1'b0 || bus_i.locked !== 1'b0) begin
      errors++;
      $display("FAIL clean_prelock got %b/%b want 0", bus_n.locked, bus_i.locked);
    end
    send_range(fr, QS, QS);
    checks++;
    if (bus_n.locked !== 1'b1 || bus_i.locked !== 1'b1) begin
      errors++;
      $display("FAIL clean_lock_edge got %b/%b want 1", bus_n.locked, bus_i.locked);
    end
    send_range(fr, QS + 1, F - 1);
    push_exp(14'h3003, 14'h0FFC);
    for (int k = 0; k < 4; k++) send_frame(14'h3003, 14'h0FFC, 1'b1);
    checks++;
    if (bus_n.sync_err_cnt !== 16'h0 || bus_i.sync_err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL clean_errcnt got %h/%h want 0", bus_n.sync_err_cnt, bus_i.sync_err_cnt);
    end
    idle(2);
    checks++;
    if (q_n.size() != 0 || q_i.size() != 0) begin
      errors++;
      $display("FAIL clean_missing_valid pending %0d/%0d want 0", q_n.size(), q_i.size());
    end
  endtask

  task automatic test_false_lock();
    do_reset();
    send_range(make_frame(14'h2AAA, 14'h0FFC), 2, F - 1);
    send_frame(14'h2AAA, 14'h0FFC, 1'b0);
    checks++;
    if (bus_n.locked !== 1'b0 || bus_i.locked !== 1'b0) begin
      errors++;
      $display("FAIL bait_prelock got %b/%b want 0", bus_n.locked, bus_i.locked);
    end
    for (int k = 0; k < 5; k++) send_frame(14'h2AAA, 14'h0FFC, 1'b1);
    checks++;
    if (bus_n.locked !== 1'b1 || bus_i.locked !== 1'b1) begin
      errors++;
      $display("FAIL bait_locked got %b/%b want 1", bus_n.locked, bus_i.locked);
    end
    idle(2);
    checks++;
    if (q_n.size() != 0 || q_i.size() != 0) begin
      errors++;
      $display("FAIL bait_missing_valid pending %0d/%0d want 0", q_n.size(), q_i.size());
    end
  endtask

  task automatic test_qsync_err();
    logic [31:0] fr;
    do_reset();
    send_frame(14'h3003, 14'h0FFC, 1'b0);
    send_frame(14'h3003, 14'h0FFC, 1'b1);
    fr = make_frame(14'h1111, 14'h2222);
    fr[31-2*QS -: 2] = 2'b11;
    send_range(fr, 0, F - 1);
    idle(0);
    checks++;
    if (bus_n.sync_err_cnt !== 16'd1 || bus_i.sync_err_cnt !== 16'd1 || bus_n.locked !== 1'b1 || bus_i.locked !== 1'b1) begin
      errors++;
      $display("FAIL qerr_count got err=%h/%h locked=%b/%b want 1/1", bus_n.sync_err_cnt, bus_i.sync_err_cnt, bus_n.locked, bus_i.locked);
    end
    send_pair(1'b1, 1'b0);
    checks++;
    if (bus_n.i_out !== 14'h3003 || bus_n.q_out !== 14'h0FFC || bus_i.i_out !== 14'h3003 || bus_i.q_out !== 14'h0FFC) begin
      errors++;
      $display("FAIL qerr_hold got n=%h/%h inv=%h/%h want 3003/0ffc", bus_n.i_out, bus_n.q_out, bus_i.i_out, bus_i.q_out);
    end
    send_range(make_frame(14'h1555, 14'h2AAA), 1, F - 1);
    push_exp(14'h1555, 14'h2AAA);
    checks++;
    if (bus_n.sync_err_cnt !== 16'd1 || bus_i.sync_err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL qerr_recover got %h/%h want 1", bus_n.sync_err_cnt, bus_i.sync_err_cnt);
    end
    idle(2);
    checks++;
    if (q_n.size() != 0 || q_i.size() != 0) begin
      errors++;
      $display("FAIL qerr_missing_valid pending %0d/%0d want 0", q_n.size(), q_i.size());
    end
  endtask

  task automatic test_lock_loss();
    logic [31:0] fr;
    do_reset();
    send_frame(14'h3003, 14'h0FFC, 1'b0);
    send_frame(14'h3003, 14'h0FFC, 1'b1);
    fr = make_frame(14'h0F0F, 14'h30C3);
    fr[31-2*QS -: 2] = 2'b11;
    send_range(fr, 0, F - 1);
    fr = make_frame(14'h3003, 14'h0FFC);
    fr[31:30] = 2'b00;
    send_range(fr, 0, 0);
    checks++;
    if (bus_n.locked !== 1'b0 || bus_i.locked !== 1'b0 || bus_n.sync_err_cnt !== 16'd2 || bus_i.sync_err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL loss_drop got locked=%b/%b err=%h/%h want 0/2", bus_n.locked, bus_i.locked, bus_n.sync_err_cnt, bus_i.sync_err_cnt);
    end
    send_range(fr, 1, F - 1);
    send_frame(14'h3003, 14'h0FFC, 1'b0);
    checks++;
    if (bus_n.locked !== 1'b0 || bus_i.locked !== 1'b0) begin
      errors++;
      $display("FAIL loss_relock_early got %b/%b want 0", bus_n.locked, bus_i.locked);
    end
    send_frame(14'h0ABC, 14'h1234, 1'b1);
    send_frame(14'h3003, 14'h0FFC, 1'b1);
    checks++;
    if (bus_n.locked !== 1'b1 || bus_i.locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_relock got %b/%b want 1", bus_n.locked, bus_i.locked);
    end
    idle(2);
    checks++;
    if (q_n.size() != 0 || q_i.size() != 0) begin
      errors++;
      $display("FAIL loss_missing_valid pending %0d/%0d want 0", q_n.size(), q_i.size());
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] fr;
    do_reset();
    send_frame(14'h3003, 14'h0FFC, 1'b0);
    send_frame(14'h3003, 14'h0FFC, 1'b1);
    fr = make_frame(14'h3003, 14'h0FFC);
    send_range(fr, 0, 4);
    rst_n = 1'b0;
    send_range(fr, 5, 5);
    rst_n = 1'b1;
    checks++;
    if (bus_n.i_out !== 14'h0 || bus_n.q_out !== 14'h0 || bus_i.i_out !== 14'h0 || bus_i.q_out !== 14'h0) begin
      errors++;
      $display("FAIL midrst_words got n=%h/%h inv=%h/%h want 0", bus_n.i_out, bus_n.q_out, bus_i.i_out, bus_i.q_out);
    end
    checks++;
    if (bus_n.locked !== 1'b0 || bus_i.locked !== 1'b0 || bus_n.sample_valid !== 1'b0 || bus_i.sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags got locked=%b/%b valid=%b/%b want 0", bus_n.locked, bus_i.locked, bus_n.sample_valid, bus_i.sample_valid);
    end
    send_range(fr, 6, F - 1);
    send_frame(14'h3003, 14'h0FFC, 1'b0);
    checks++;
    if (bus_n.i_out !== 14'h0 || bus_i.i_out !== 14'h0) begin
      errors++;
      $display("FAIL midrst_no_partial got %h/%h want 0", bus_n.i_out, bus_i.i_out);
    end
    send_frame(14'h2AAA, 14'h1555, 1'b1);
    send_frame(14'h3003, 14'h0FFC, 1'b1);
    idle(2);
    checks++;
    if (q_n.size() != 0 || q_i.size() != 0) begin
      errors++;
      $display("FAIL midrst_missing_valid pending %0d/%0d want 0", q_n.size(), q_i.size());
    end
  endtask

  task automatic test_invert();
    do_reset();
    send_frame(14'h1234, 14'h0ABC, 1'b0);
    for (int k = 0; k < 3; k++) send_frame(14'h1234, 14'h0ABC, 1'b1);
    checks++;
    if (bus_n.locked !== 1'b1 || bus_i.locked !== 1'b1 || bus_n.sync_err_cnt !== 16'h0 || bus_i.sync_err_cnt !== 16'h0) begin
      errors++;
      $display("FAIL invert_lock got locked=%b/%b err=%h/%h want 1/0", bus_n.locked, bus_i.locked, bus_n.sync_err_cnt, bus_i.sync_err_cnt);
    end
    idle(2);
    checks++;
    if (q_n.size() != 0 || q_i.size() != 0) begin
      errors++;
      $display("FAIL invert_missing_valid pending %0d/%0d want 0", q_n.size(), q_i.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_n.din_rise = 1'b0;
    bus_n.din_fall = 1'b0;
    bus_i.din_rise = 1'b1;
    bus_i.din_fall = 1'b1;
    test_reset();
    test_clean();
    test_false_lock();
    test_qsync_err();
    test_lock_loss();
    test_mid_reset();
    test_invert();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
